// File: rtl/i2c_tgt_pkg.sv
// Shared types and bit-level constants for the I2C target register file.
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Pad-line conditioner: synchronizer, optional glitch filter (I2C_TGT_GLITCH_FILT_EN),
// registered level plus one-cycle rise/fall pulses. Idle level is high.
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef I2C_TGT_GLITCH_FILT_EN
    , parameter int unsigned FILT_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_line,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_samp;
    logic                   w_next;
    logic                   r_line;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
        end
    end

    assign w_samp = r_sync[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILT_EN
    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // Accept a new level only once it has been seen FILT_LEN samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (w_samp == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILT_LEN - 1)) begin
            r_filt <= w_samp;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_next = r_filt;
`else
    assign w_next = w_samp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_line <= w_next;
            r_rise <= w_next & ~r_line;
            r_fall <= ~w_next & r_line;
        end
    end

    assign o_line = r_line;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target with a byte register file shared with a local user port.
// Optional glitch filter on SCL/SDA is enabled by defining I2C_TGT_GLITCH_FILT_EN.
module i2c_target_regfile
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h66,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned PTR_BYTES   = 1,
    parameter int unsigned SYNC_STAGES = 2
`ifdef I2C_TGT_GLITCH_FILT_EN
    , parameter int unsigned FILT_LEN  = 3
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl_i,
    input  logic                         sda_i,
    output logic                         sda_oe,
    input  logic                         usr_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] usr_addr,
    input  logic [7:0]                   usr_wdata,
    output logic [7:0]                   usr_rdata,
    output logic                         wr_valid,
    output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         busy
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned PW = 8 * PTR_BYTES;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

`ifdef I2C_TGT_GLITCH_FILT_EN
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_cond (
`else
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl_cond (
`endif
        .clk    (clk),
        .rst    (rst),
        .i_line (scl_i),
        .o_line (w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

`ifdef I2C_TGT_GLITCH_FILT_EN
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_cond (
`else
    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda_cond (
`endif
        .clk    (clk),
        .rst    (rst),
        .i_line (sda_i),
        .o_line (w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    state_t          r_state;
    logic [3:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_rw;
    logic            r_ack_ph;
    logic [AW-1:0]   r_ptr;
    logic [PW-1:0]   r_ptr_acc;
    logic [1:0]      r_ptr_cnt;
    logic            r_sda_oe;
    logic            r_busy;
    logic            r_wr_valid;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic [7:0]      r_usr_rdata;
    logic [7:0]      r_mem [MEM_DEPTH];

    logic            w_start;
    logic            w_stop;
    logic [7:0]      w_byte;
    logic [PW-1:0]   w_acc_next;
    logic [AW-1:0]   w_ptr_inc;
    logic [7:0]      w_rd_cur;
    logic [7:0]      w_rd_next;
    logic            w_i2c_we;

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_acc_next = PW'({r_ptr_acc, w_byte});
    assign w_ptr_inc  = r_ptr + AW'(1);
    assign w_rd_cur   = r_mem[r_ptr];
    assign w_rd_next  = r_mem[w_ptr_inc];
    assign w_i2c_we   = !rst && !w_start && !w_stop && (r_state == WDATA)
                        && w_scl_rise && (r_bitcnt == 4'd7);

    // Protocol FSM; START/STOP take priority over every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_rw       <= 1'b0;
            r_ack_ph   <= 1'b0;
            r_ptr      <= '0;
            r_ptr_acc  <= '0;
            r_ptr_cnt  <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: if (w_scl_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            if (r_shift[6:0] == SLV_ADDR) begin
                                r_state  <= ADDR_ACK;
                                r_rw     <= w_sda;
                                r_ack_ph <= 1'b0;
                                r_busy   <= 1'b1;
                            end else begin
                                r_state <= IGNORE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            r_sda_oe <= 1'b1;
                            r_ack_ph <= 1'b1;
                        end else begin
                            r_bitcnt <= '0;
                            r_ack_ph <= 1'b0;
                            if (r_rw) begin
                                r_state  <= RDATA;
                                r_shift  <= w_rd_cur;
                                r_sda_oe <= ~w_rd_cur[7];
                            end else begin
                                r_state   <= PTR;
                                r_sda_oe  <= 1'b0;
                                r_ptr_cnt <= '0;
                                r_ptr_acc <= '0;
                            end
                        end
                    end
                    PTR: if (w_scl_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_ptr_acc <= w_acc_next;
                            r_ptr_cnt <= r_ptr_cnt + 2'd1;
                            if (r_ptr_cnt == 2'(PTR_BYTES - 1)) begin
                                r_ptr <= AW'(w_acc_next);
                            end
                            r_state  <= PTR_ACK;
                            r_ack_ph <= 1'b0;
                        end
                    end
                    PTR_ACK: if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            r_sda_oe <= 1'b1;
                            r_ack_ph <= 1'b1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_ack_ph <= 1'b0;
                            r_bitcnt <= '0;
                            r_state  <= (r_ptr_cnt == 2'(PTR_BYTES)) ? WDATA : PTR;
                        end
                    end
                    WDATA: if (w_scl_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_ptr;
                            r_wr_data  <= w_byte;
                            r_ptr      <= w_ptr_inc;
                            r_state    <= WDATA_ACK;
                            r_ack_ph   <= 1'b0;
                        end
                    end
                    WDATA_ACK: if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            r_sda_oe <= 1'b1;
                            r_ack_ph <= 1'b1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_ack_ph <= 1'b0;
                            r_bitcnt <= '0;
                            r_state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= RDATA_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[3'(4'd7 - r_bitcnt)];
                            end
                        end
                    end
                    RDATA_ACK: if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            r_ptr    <= w_ptr_inc;
                            r_shift  <= w_rd_next;
                            r_bitcnt <= '0;
                            r_state  <= RDATA;
                        end else begin
                            r_state <= IGNORE;
                            r_busy  <= 1'b0;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Register file; the I2C write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (usr_we) begin
            r_mem[usr_addr] <= usr_wdata;
        end
        if (w_i2c_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_usr_rdata <= '0;
        end else begin
            r_usr_rdata <= r_mem[usr_addr];
        end
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign usr_rdata = r_usr_rdata;

endmodule
